// File: rtl/icache_axi_refill.sv
// Instruction-cache line refill over an AXI3 read port: one INCR burst of
// BEATS 32-bit words per request, line handed back with a one-cycle grant.
module icache_axi_refill #(
   parameter logic [3:0]  AR_ID = 4'd0,
   parameter int unsigned BEATS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_rd_req,
   input  logic [31:0] icache_addr,
   output logic        icache_gnt,
   output logic [31:0] icache_data [0:BEATS-1],
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam int unsigned CW = $clog2(BEATS);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_RD, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full_q, full_d;
   logic [31:0]   data_q [0:BEATS-1];
   logic [31:0]   data_d [0:BEATS-1];
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic          gnt_q, gnt_d;
   logic          beat_ok;
   logic          unused_rresp;

   // Error responses are stored like any other data.
   assign unused_rresp = ^rresp;

   assign beat_ok = rvalid && rready_q && (rid == AR_ID);

   // Next state, line write and registered output decode.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (icache_rd_req) begin
               addr_d  = {icache_addr[31:5], 5'b0};
               cnt_d   = '0;
               full_d  = 1'b0;
               state_d = S_AR;
            end
         end
         S_AR: begin
            if (arvalid_q && arready) state_d = S_RD;
         end
         S_RD: begin
            if (beat_ok) begin
               // Once the last word is written, surplus beats are dropped until rlast.
               if (!full_q) begin
                  data_d[cnt_q] = rdata;
                  if (cnt_q == CW'(BEATS - 1)) full_d = 1'b1;
                  else                         cnt_d  = cnt_q + CW'(1);
               end
               if (rlast) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      arvalid_d = (state_d == S_AR);
      rready_d  = (state_d == S_RD);
      gnt_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         full_q    <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         gnt_q     <= 1'b0;
         for (int i = 0; i < int'(BEATS); i++) data_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         full_q    <= full_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         gnt_q     <= gnt_d;
         data_q    <= data_d;
      end
   end

   assign icache_data = data_q;
   assign icache_gnt  = gnt_q;
   assign arvalid     = arvalid_q;
   assign rready      = rready_q;
   assign araddr      = addr_q;
   assign arid        = AR_ID;
   assign arlen       = 4'(BEATS - 1);
   assign arsize      = 3'b010;
   assign arburst     = 2'b01;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: transaction-level reference model checked every
// cycle, plus directed refill scenarios with literal expectations.
module tb_icache_axi_refill;

   localparam logic [3:0] ID = 4'd0;

   logic        clk;
   logic        rst;
   logic        icache_rd_req;
   logic [31:0] icache_addr;
   logic        icache_gnt;
   logic [31:0] icache_data [0:7];
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   icache_axi_refill #(.AR_ID(ID), .BEATS(8)) dut (
      .clk(clk), .rst(rst),
      .icache_rd_req(icache_rd_req), .icache_addr(icache_addr),
      .icache_gnt(icache_gnt), .icache_data(icache_data),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int t_req = 0;
   int ar_cnt = 0;

   // Reference: phase of the current refill (0 idle, 1 address, 2 data, 3 grant).
   int          m_ph;
   logic [31:0] m_addr;
   int          m_wr;
   logic [31:0] m_line [0:7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (rst && arvalid && arready) ar_cnt++;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ph = 0; m_addr = '0; m_wr = 0;
         for (int i = 0; i < 8; i++) m_line[i] = '0;
      end else begin
         case (m_ph)
            0: if (icache_rd_req) begin
                  m_addr = icache_addr & 32'hFFFF_FFE0;
                  m_wr = 0;
                  m_ph = 1;
               end
            1: if (arready) m_ph = 2;
            2: if (rvalid && rid == ID) begin
                  if (m_wr < 8) m_line[m_wr] = rdata;
                  m_wr++;
                  if (rlast) m_ph = 3;
               end
            default: m_ph = 0;
         endcase
      end
   end

   // Every cycle: outputs must match the reference phase and line image.
   always @(negedge clk) begin
      chk("arvalid", 32'(arvalid), 32'(m_ph == 1));
      chk("rready", 32'(rready), 32'(m_ph == 2));
      chk("gnt", 32'(icache_gnt), 32'(m_ph == 3));
      if (m_ph == 1) begin
         chk("araddr", araddr, m_addr);
         chk("arlen", 32'(arlen), 32'd7);
         chk("arsize", 32'(arsize), 32'd2);
         chk("arburst", 32'(arburst), 32'd1);
         chk("arid", 32'(arid), 32'(ID));
      end
      for (int i = 0; i < 8; i++) chk($sformatf("word%0d", i), icache_data[i], m_line[i]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic [31:0] a);
      icache_rd_req = 1'b1;
      icache_addr   = a;
      tick();
      t_req = cyc;
      icache_addr = ~a;
   endtask

   task automatic ar_go(input int stall);
      arready = 1'b0;
      for (int k = 0; k < stall; k++) begin
         chk("stall_arvalid", 32'(arvalid), 32'd1);
         tick();
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] id, input bit last, input bit gap);
      if (gap) begin
         rvalid = 1'b0;
         tick();
      end
      rvalid = 1'b1; rid = id; rdata = d; rlast = last;
      tick();
      rvalid = 1'b0; rlast = 1'b0; rid = ID; rdata = '0;
   endtask

   task automatic wait_gnt(input bit hold, output int lat);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         if (icache_gnt) begin
            lat = cyc - t_req;
            break;
         end
         tick();
      end
      if (lat < 0) begin
         n_cmp++; n_bad++;
         $display("FAIL gnt_timeout: no grant within 40 cycles (t=%0t)", $time);
      end
      if (hold) tick();
      icache_rd_req = 1'b0;
      tick();
   endtask

   task automatic chk_line(input string nm, input logic [31:0] base);
      for (int i = 0; i < 8; i++) chk($sformatf("%s_w%0d", nm, i), icache_data[i], base + 32'(i));
   endtask

   initial begin
      int lat;
      int ar0;
      rst = 1'b0; icache_rd_req = 1'b0; icache_addr = '0;
      arready = 1'b0; rvalid = 1'b0; rid = ID; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      m_ph = 0; m_addr = '0; m_wr = 0;
      for (int i = 0; i < 8; i++) m_line[i] = '0;
      repeat (3) tick();
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_gnt", 32'(icache_gnt), 32'd0);
      chk("rst_araddr", araddr, 32'd0);

      // Basic back-to-back refill, request on first edge out of reset.
      rst = 1'b1;
      start_req(32'h1FC0_0014);
      chk("t1_araddr", araddr, 32'h1FC0_0000);
      chk("t1_arlen", 32'(arlen), 32'd7);
      ar_go(0);
      for (int i = 0; i < 8; i++) beat(32'hA0 + 32'(i), ID, i == 7, 1'b0);
      wait_gnt(1'b0, lat);
      chk("t1_gnt_lat", 32'(lat), 32'd9);
      chk_line("t1", 32'hA0);

      // Address stall of 5 cycles with stray data on the R channel.
      start_req(32'h0000_1234);
      rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
      for (int k = 0; k < 5; k++) begin
         chk("t2_araddr", araddr, 32'h0000_1220);
         chk("t2_rready", 32'(rready), 32'd0);
         chk("t2_arvalid", 32'(arvalid), 32'd1);
         tick();
      end
      rvalid = 1'b0;
      ar_go(0);
      for (int i = 0; i < 8; i++) beat(32'hB0 + 32'(i), ID, i == 7, 1'b0);
      wait_gnt(1'b0, lat);
      chk("t2_gnt_lat", 32'(lat), 32'd14);
      chk_line("t2", 32'hB0);

      // Gapped beats, foreign-ID beat interleaved, error responses.
      start_req(32'h8000_0040);
      ar_go(0);
      rresp = 2'b10;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) beat(32'h0000_DEAD, 4'd3, 1'b0, 1'b1);
         beat(32'hC0 + 32'(i), ID, i == 7, 1'b1);
      end
      rresp = 2'b00;
      wait_gnt(1'b0, lat);
      chk_line("t3", 32'hC0);

      // Early rlast on beat 4 keeps words 4..7 of the previous line.
      start_req(32'h0000_2000);
      ar_go(0);
      for (int i = 0; i < 8; i++) beat(32'h1111_1100 + 32'(i), ID, i == 7, 1'b0);
      wait_gnt(1'b0, lat);
      start_req(32'h0000_3000);
      ar_go(1);
      for (int i = 0; i < 4; i++) beat(32'h2222_2200 + 32'(i), ID, i == 3, 1'b0);
      wait_gnt(1'b0, lat);
      chk("t4_gnt_seen", 32'(lat > 0), 32'd1);
      for (int i = 0; i < 4; i++) chk($sformatf("t4_new%0d", i), icache_data[i], 32'h2222_2200 + 32'(i));
      for (int i = 4; i < 8; i++) chk($sformatf("t4_old%0d", i), icache_data[i], 32'h1111_1100 + 32'(i));

      // Ten beats before rlast: only the first eight are kept.
      start_req(32'h0000_4000);
      ar_go(0);
      for (int i = 0; i < 10; i++) beat(32'hE0 + 32'(i), ID, i == 9, 1'b0);
      wait_gnt(1'b0, lat);
      chk_line("t5", 32'hE0);

      // Reset in the middle of a burst, then a clean refill.
      start_req(32'h0000_5000);
      ar_go(0);
      for (int i = 0; i < 3; i++) beat(32'hF0 + 32'(i), ID, 1'b0, 1'b0);
      rvalid = 1'b1; rdata = 32'hF3;
      rst = 1'b0; icache_rd_req = 1'b0;
      #1;
      chk("t6_rready", 32'(rready), 32'd0);
      chk("t6_arvalid", 32'(arvalid), 32'd0);
      chk("t6_gnt", 32'(icache_gnt), 32'd0);
      for (int i = 0; i < 8; i++) chk($sformatf("t6_clr%0d", i), icache_data[i], 32'd0);
      rvalid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      start_req(32'h0000_6008);
      chk("t6_araddr", araddr, 32'h0000_6000);
      ar_go(0);
      for (int i = 0; i < 8; i++) beat(32'h3333_3300 + 32'(i), ID, i == 7, 1'b0);
      wait_gnt(1'b0, lat);
      chk("t6_gnt_lat", 32'(lat), 32'd9);
      chk_line("t6", 32'h3333_3300);

      // Request held through the grant cycle: one AR only, line stays put.
      ar0 = ar_cnt;
      start_req(32'h0000_7000);
      ar_go(0);
      for (int i = 0; i < 8; i++) beat(32'h4444_4400 + 32'(i), ID, i == 7, 1'b0);
      arready = 1'b1;
      wait_gnt(1'b1, lat);
      chk_line("t7", 32'h4444_4400);
      repeat (3) tick();
      arready = 1'b0;
      chk("t7_ar_count", 32'(ar_cnt - ar0), 32'd1);
      chk("t7_idle_arvalid", 32'(arvalid), 32'd0);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
